ddr_write_burst: RTL and testbench
==================================

Name: ddr_write_burst

Overview:
- Responder side of the arbitrator's write command interface.
- Accepts one write command per transaction: a one-cycle `write_in` pulse, a 32-bit address and a 768-bit data block.
- Serialises the block into six 128-bit beats and issues them as three 2-beat (BL4, 64-bit DRAM) writes into the DDR2 controller's address and write-data FIFOs.
- Drives `w_busy` back to the arbitrator while a transaction is in flight.

Parameters:
- ADDR_STEP, 4, app_af_addr increment between consecutive address commands (column units per BL4 burst).
- NUM_CMDS, 3, address commands per transaction; 2 data beats each; NUM_CMDS*2*128 must equal 768.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- phy_init_done  input  1  DDR2 calibration complete; commands are accepted only when high.
- write_in  input  1  one-cycle write command strobe.
- w_address_in  input  32  base address; bits [30:0] used.
- w_data_in  input  768  data block; valid while write_in=1.
- w_busy  output  1  transaction in flight.
- app_af_afull  input  1  controller address FIFO almost full.
- app_wdf_afull  input  1  controller write-data FIFO almost full.
- app_af_wren  output  1  address FIFO write enable.
- app_af_cmd  output  3  command; always 3'b000 (write).
- app_af_addr  output  31  command address.
- app_wdf_wren  output  1  write-data FIFO write enable.
- app_wdf_data  output  128  data beat.
- app_wdf_mask_data  output  16  byte mask; always 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, internal capture registers and counters 0.
- All outputs are registered.
- States:
  - IDLE: on a clk edge with write_in=1 and phy_init_done=1, capture w_address_in[30:0] and w_data_in, set cmd index=0, go to BEAT_A. Otherwise stay in IDLE.
  - BEAT_A: if app_af_afull=0 and app_wdf_afull=0, drive app_af_wren=1, app_af_addr=base+ADDR_STEP*idx (mod 2^31), app_wdf_wren=1, app_wdf_data=word[2*idx], then go to BEAT_B. Otherwise stall: both wren=0 and state holds.
  - BEAT_B: if app_wdf_afull=0, drive app_wdf_wren=1, app_wdf_data=word[2*idx+1]. Then if idx=NUM_CMDS-1 go to IDLE, else idx+1 and go to BEAT_A. Otherwise stall with app_wdf_wren=0.
- Word k = w_data_in[128k+127:128k]; k=0 is sent first.
- Strobe timing: app_af_wren and app_wdf_wren are single-cycle per beat and deasserted in every cycle without a beat. app_wdf_data holds its last value when no beat is issued.
- w_busy:
  - Rises in the cycle after acceptance and stays high through the final beat.
  - Is low in the cycle after the final beat.
  - With no stalls: write_in at edge T gives beats in cycles T+1..T+6, w_busy=1 in T+1..T+6, and w_busy=0 at T+7.
- write_in while w_busy=1, or in the same edge the last beat completes: the command is ignored and the captured data is not overwritten. The arbitrator guarantees it holds commands while w_busy=1.
- write_in while phy_init_done=0: ignored.
- phy_init_done falling mid-transaction: no effect; the burst completes.
- Reset asserted mid-transaction: immediate abort to IDLE, all outputs 0. Partially written controller FIFO contents are not retracted.
- Address wrap: base+8 past 2^31-1 wraps modulo 2^31.

Optional Feature:
- Macro: WRITE_BURST_DROP_CNT_EN.
- Defined:
  - Adds output drop_count[15:0], reset to 0.
  - Increments by 1, saturating at 16'hFFFF, on every edge where write_in=1 and the command is ignored (busy or phy_init_done=0).
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- No stalls: after reset release with phy_init_done=1, pulse write_in with addr=32'h0000_0100 and data words k=0..5 set to {16{8'h10+k}}. Required: app_af_addr 0x100, 0x104, 0x108 in cycles T+1, T+3, T+5; 6 wdf beats in order T+1..T+6; w_busy high T+1..T+6, low at T+7.
- Stalls: hold app_af_afull=1 for cycles T+1..T+3 and app_wdf_afull=1 at cycle T+5. Required: no wren in stalled cycles; beat order and addresses unchanged; w_busy falls the cycle after the 6th beat.
- Overlap: assert write_in with addr=0x200 at T+2 during a busy transaction. Required: ignored, and the first transaction's data is intact. With WRITE_BURST_DROP_CNT_EN defined, drop_count=1.
- Wrap: addr=32'h7FFF_FFFC. Required: app_af_addr sequence 0x7FFFFFFC, 0x00000000, 0x00000004.
- Calibration gate: phy_init_done=0 with a write_in pulse. Required: no wren and w_busy=0.
- Reset mid-burst: reset=0 asynchronously at T+3. Required: all outputs 0 in that cycle, state IDLE. The next write_in after reset release runs a full 6-beat burst.

Source files
------------

// File: rtl/ddr_write_burst_if.sv
// rtl/ddr_write_burst_if.sv - DDR2 controller address/write-data FIFO bus
interface ddr_write_burst_if;
    logic         app_af_afull;
    logic         app_wdf_afull;
    logic         app_af_wren;
    logic [2:0]   app_af_cmd;
    logic [30:0]  app_af_addr;
    logic         app_wdf_wren;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask_data;

    modport master (
        input  app_af_afull,
        input  app_wdf_afull,
        output app_af_wren,
        output app_af_cmd,
        output app_af_addr,
        output app_wdf_wren,
        output app_wdf_data,
        output app_wdf_mask_data
    );

    modport slave (
        output app_af_afull,
        output app_wdf_afull,
        input  app_af_wren,
        input  app_af_cmd,
        input  app_af_addr,
        input  app_wdf_wren,
        input  app_wdf_data,
        input  app_wdf_mask_data
    );
endinterface

// File: rtl/ddr_write_burst.sv
// rtl/ddr_write_burst.sv - serialises a 768-bit write into three BL4 DDR2 writes
// Optional ignored-command counter: define WRITE_BURST_DROP_CNT_EN.
module ddr_write_burst #(
    parameter int ADDR_STEP = 4,
    parameter int NUM_CMDS  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      phy_init_done,
    input  logic                      write_in,
    input  logic [31:0]               w_address_in,
    input  logic [NUM_CMDS*256-1:0]   w_data_in,
    output logic                      w_busy,
`ifdef WRITE_BURST_DROP_CNT_EN
    output logic [15:0]               drop_count,
`endif
    ddr_write_burst_if.master         app
);

    localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT_A = 2'd1,
        BEAT_B = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [30:0]                     addr_q;
    logic [2*NUM_CMDS-1:0][127:0]    data_q;
    logic [IDX_W-1:0]                idx;

    logic         accept;
    logic         beat_a_go;
    logic         beat_b_go;
    logic         last_cmd;
    logic [30:0]  cmd_addr;
    logic [127:0] word_a;
    logic [127:0] word_b;

    logic         af_wren_d;
    logic         wdf_wren_d;
    logic [30:0]  addr_d;
    logic [127:0] data_d;
    logic         busy_d;

    logic unused_addr_msb;
    assign unused_addr_msb = w_address_in[31];

    // Only IDLE accepts, so commands arriving mid-burst (including the last-beat edge) drop out here.
    assign accept    = (state == IDLE) && write_in && phy_init_done;
    assign beat_a_go = (state == BEAT_A) && !app.app_af_afull && !app.app_wdf_afull;
    assign beat_b_go = (state == BEAT_B) && !app.app_wdf_afull;
    assign last_cmd  = (idx == IDX_W'(NUM_CMDS - 1));
    assign cmd_addr  = addr_q + 31'(ADDR_STEP * int'(idx));
    assign word_a    = data_q[{idx, 1'b0}];
    assign word_b    = data_q[{idx, 1'b1}];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BEAT_A;
                end
            end
            BEAT_A: begin
                if (beat_a_go) begin
                    state_nxt = BEAT_B;
                end
            end
            BEAT_B: begin
                if (beat_b_go) begin
                    state_nxt = last_cmd ? IDLE : BEAT_A;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Busy tracks the registered state so it lines up with the registered strobes.
    always_comb begin
        af_wren_d  = 1'b0;
        wdf_wren_d = 1'b0;
        addr_d     = app.app_af_addr;
        data_d     = app.app_wdf_data;
        busy_d     = (state != IDLE);
        if (beat_a_go) begin
            af_wren_d  = 1'b1;
            wdf_wren_d = 1'b1;
            addr_d     = cmd_addr;
            data_d     = word_a;
        end else if (beat_b_go) begin
            wdf_wren_d = 1'b1;
            data_d     = word_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            app.app_af_wren  <= 1'b0;
            app.app_wdf_wren <= 1'b0;
            app.app_af_addr  <= '0;
            app.app_wdf_data <= '0;
            w_busy           <= 1'b0;
        end else begin
            app.app_af_wren  <= af_wren_d;
            app.app_wdf_wren <= wdf_wren_d;
            app.app_af_addr  <= addr_d;
            app.app_wdf_data <= data_d;
            w_busy           <= busy_d;
        end
    end

    assign app.app_af_cmd        = 3'b000;
    assign app.app_wdf_mask_data = 16'h0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
            idx    <= '0;
        end else if (accept) begin
            addr_q <= w_address_in[30:0];
            data_q <= w_data_in;
            idx    <= '0;
        end else if (beat_b_go && !last_cmd) begin
            idx <= idx + 1'b1;
        end
    end

`ifdef WRITE_BURST_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= 16'h0000;
        end else if (write_in && !accept && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_write_burst.sv
// tb/tb_ddr_write_burst.sv - directed self-checking bench for ddr_write_burst
module tb_ddr_write_burst;

    logic         clk;
    logic         reset;
    logic         phy_init_done;
    logic         write_in;
    logic [31:0]  w_address_in;
    logic [767:0] w_data_in;
    logic         w_busy;
`ifdef WRITE_BURST_DROP_CNT_EN
    logic [15:0]  drop_count;
`endif

    ddr_write_burst_if bus ();

    ddr_write_burst dut (
        .clk           (clk),
        .reset         (reset),
        .phy_init_done (phy_init_done),
        .write_in      (write_in),
        .w_address_in  (w_address_in),
        .w_data_in     (w_data_in),
        .w_busy        (w_busy),
`ifdef WRITE_BURST_DROP_CNT_EN
        .drop_count    (drop_count),
`endif
        .app           (bus)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [767:0] mk(input logic [7:0] seed);
        logic [767:0] d;
        for (int k = 0; k < 6; k++) begin
            d[k*128 +: 128] = {16{seed + 8'(k)}};
        end
        return d;
    endfunction

    // Offsets are edges after the accepting edge T; mask bit n = strobe seen after edge T+n,
    // stall bit n = afull sampled at edge T+n.
    task automatic run_burst(input string tag, input logic [31:0] addr, input logic [7:0] seed,
                             input logic [30:0] ea0, input logic [30:0] ea1, input logic [30:0] ea2,
                             input logic [15:0] af_mask, input logic [15:0] wdf_mask,
                             input logic [15:0] af_stall, input logic [15:0] wdf_stall,
                             input int last, input int ov_off, input logic [31:0] ov_addr);
        logic [30:0] ea [3];
        logic [7:0]  b;
        int cmd;
        int beat;
        ea[0] = ea0; ea[1] = ea1; ea[2] = ea2;
        cmd = 0;
        beat = 0;
        @(negedge clk);
        w_address_in = addr;
        w_data_in    = mk(seed);
        write_in     = 1'b1;
        for (int off = 0; off <= last + 1; off++) begin
            @(negedge clk);
            write_in = 1'b0;
            bus.app_af_afull  = af_stall[off+1];
            bus.app_wdf_afull = wdf_stall[off+1];
            if (off == ov_off) begin
                write_in     = 1'b1;
                w_address_in = ov_addr;
                w_data_in    = mk(8'hA0);
            end
            check($sformatf("%s busy@%0d", tag, off), w_busy, (off >= 1 && off <= last));
            check($sformatf("%s af_wren@%0d", tag, off), bus.app_af_wren, af_mask[off]);
            if (af_mask[off] && cmd < 3) begin
                check($sformatf("%s addr%0d", tag, cmd), bus.app_af_addr, ea[cmd]);
                cmd++;
            end
            check($sformatf("%s wdf_wren@%0d", tag, off), bus.app_wdf_wren, wdf_mask[off]);
            if (wdf_mask[off]) begin
                b = seed + 8'(beat);
                check($sformatf("%s data%0d", tag, beat), bus.app_wdf_data, {16{b}});
                beat++;
            end
        end
        bus.app_af_afull  = 1'b0;
        bus.app_wdf_afull = 1'b0;
        write_in          = 1'b0;
    endtask

    initial begin
        reset             = 1'b0;
        phy_init_done     = 1'b0;
        write_in          = 1'b0;
        w_address_in      = '0;
        w_data_in         = '0;
        bus.app_af_afull  = 1'b0;
        bus.app_wdf_afull = 1'b0;

        repeat (2) @(negedge clk);
        check("rst busy", w_busy, 1'b0);
        check("rst af_wren", bus.app_af_wren, 1'b0);
        check("rst wdf_wren", bus.app_wdf_wren, 1'b0);
        check("rst addr", bus.app_af_addr, 31'h0);
        check("rst data", bus.app_wdf_data, 128'h0);
        check("rst cmd", bus.app_af_cmd, 3'b000);
        check("rst mask", bus.app_wdf_mask_data, 16'h0000);
`ifdef WRITE_BURST_DROP_CNT_EN
        check("rst drop", drop_count, 16'h0000);
`endif
        reset = 1'b1;
        phy_init_done = 1'b1;
        @(negedge clk);

        run_burst("nostall", 32'h0000_0100, 8'h10, 31'h100, 31'h104, 31'h108,
                  16'h002A, 16'h007E, 16'h0000, 16'h0000, 6, -1, 32'h0);

        run_burst("stall", 32'h0000_1000, 8'h20, 31'h1000, 31'h1004, 31'h1008,
                  16'h0290, 16'h07D0, 16'h000E, 16'h0020, 10, -1, 32'h0);

        run_burst("overlap", 32'h0000_0300, 8'h40, 31'h300, 31'h304, 31'h308,
                  16'h002A, 16'h007E, 16'h0000, 16'h0000, 6, 1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("overlap idle busy%0d", i), w_busy, 1'b0);
            check($sformatf("overlap idle af_wren%0d", i), bus.app_af_wren, 1'b0);
        end
`ifdef WRITE_BURST_DROP_CNT_EN
        check("overlap drop", drop_count, 16'h0001);
`endif

        run_burst("wrap", 32'h7FFF_FFFC, 8'h50, 31'h7FFF_FFFC, 31'h0000_0000, 31'h0000_0004,
                  16'h002A, 16'h007E, 16'h0000, 16'h0000, 6, -1, 32'h0);

        phy_init_done = 1'b0;
        @(negedge clk);
        w_address_in = 32'h0000_0600;
        w_data_in    = mk(8'h60);
        write_in     = 1'b1;
        @(negedge clk);
        write_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("gate busy%0d", i), w_busy, 1'b0);
            check($sformatf("gate af_wren%0d", i), bus.app_af_wren, 1'b0);
            check($sformatf("gate wdf_wren%0d", i), bus.app_wdf_wren, 1'b0);
        end
`ifdef WRITE_BURST_DROP_CNT_EN
        check("gate drop", drop_count, 16'h0002);
`endif
        phy_init_done = 1'b1;

        @(negedge clk);
        w_address_in = 32'h0000_0400;
        w_data_in    = mk(8'h70);
        write_in     = 1'b1;
        @(negedge clk);
        write_in = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst pre af_wren", bus.app_af_wren, 1'b1);
        check("midrst pre addr", bus.app_af_addr, 31'h404);
        #1 reset = 1'b0;
        #1;
        check("midrst busy", w_busy, 1'b0);
        check("midrst af_wren", bus.app_af_wren, 1'b0);
        check("midrst wdf_wren", bus.app_wdf_wren, 1'b0);
        check("midrst addr", bus.app_af_addr, 31'h0);
        check("midrst data", bus.app_wdf_data, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst busy", w_busy, 1'b0);
        check("postrst wdf_wren", bus.app_wdf_wren, 1'b0);

        run_burst("afterrst", 32'h0000_0500, 8'h80, 31'h500, 31'h504, 31'h508,
                  16'h002A, 16'h007E, 16'h0000, 16'h0000, 6, -1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
